// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_prefetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] WORD_INC         = 32'd4;

  typedef enum logic {
    RUN,
    FLUSH
  } fetch_state_e;

  // One prefetch buffer entry: instruction word plus the address after it.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Redirect/stall control, instruction-memory bus and decode-side outputs.
interface fetch_prefetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_plus_four;

  // Fetch unit side.
  modport master (
    input  redirect, redirect_pc, stall, imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_req_addr, inst_valid, inst_out, pc_plus_four
  );

  // Environment side (instruction memory and decode).
  modport slave (
    output redirect, redirect_pc, stall, imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_out, pc_plus_four
  );
endinterface

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous show-ahead FIFO; clear has priority over push/pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full && !clear;
  assign do_pop    = pop && !empty && !clear;

  // Storage write at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: PC, request issue, in-order response capture, redirect flush.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_prefetch_unit_if.master bus
);
  localparam int unsigned CW  = $clog2(DEPTH) + 2;
  localparam int unsigned FCW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [FCW-1:0] fifo_count;
  logic           fifo_empty, fifo_full;
  logic [63:0]    head_raw;
  fetch_entry_t   head, push_entry;
  logic           req_valid, req_hs, resp_any, push, pop;
  logic [31:0]    redirect_word;

  assign redirect_word = {bus.redirect_pc[31:2], 2'b00};
  assign head          = fetch_entry_t'(head_raw);

  // Issue gating: buffer space covers everything in flight, and dropped
  // responses still occupy memory-side request slots.
  always_comb begin
    req_valid = !reset && !bus.redirect
                && ((CW'(fifo_count) + out_q) < CW'(DEPTH))
                && ((drop_q + out_q) < CW'(MAX_OUTSTANDING));
    req_hs    = req_valid && bus.imem_req_ready;
    // A response with nothing pending is stray and ignored entirely.
    resp_any  = bus.imem_resp_valid && ((drop_q != '0) || (out_q != '0));
    pop       = !fifo_empty && !bus.stall && !bus.redirect;
  end

  // Next-state logic; redirect overrides stall, response and dequeue.
  always_comb begin
    state_d          = state_q;
    pc_d             = req_hs ? pc_q + WORD_INC : pc_q;
    resp_pc_d        = resp_pc_q;
    out_d            = out_q;
    drop_d           = drop_q;
    push             = 1'b0;
    push_entry.instr = bus.imem_resp_data;
    push_entry.pc4   = resp_pc_q + WORD_INC;
    if (bus.redirect) begin
      // Everything in flight becomes a drop; a response this cycle already
      // retires the oldest of them.
      pc_d      = redirect_word;
      resp_pc_d = redirect_word;
      drop_d    = drop_q + out_q + CW'(req_hs) - CW'(resp_any);
      out_d     = '0;
      state_d   = (drop_d != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN: begin
          out_d = out_q + CW'(req_hs) - CW'(resp_any);
          if (resp_any) begin
            push      = !fifo_full;
            resp_pc_d = resp_pc_q + WORD_INC;
          end
        end
        FLUSH: begin
          // Responses to pre-redirect requests come first; discard them.
          out_d = out_q + CW'(req_hs);
          if (resp_any) drop_d = drop_q - 1'b1;
          if (drop_d == '0) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .clear     (bus.redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_raw),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = !fifo_empty;
  assign bus.inst_out       = fifo_empty ? NOP_INSTR : head.instr;
  assign bus.pc_plus_four   = fifo_empty ? '0 : head.pc4;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit with an in-order latency memory model.
module tb_fetch_prefetch_unit;
  import fetch_prefetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  fetch_prefetch_unit_if bus();

  fetch_prefetch_unit #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned consumed = 0;
  logic [63:0] sb [$];

  // Memory model state: pending request addresses and the cycle each may respond.
  logic [31:0] pend_addr [$];
  int unsigned pend_due  [$];
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;
  logic        hs_s = 1'b0, rst_s = 1'b1, given_s = 1'b0;
  logic [31:0] hs_addr_s = '0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_stream(input logic [31:0] start);
    logic [31:0] a;
    sb.delete();
    for (int i = 0; i < 96; i++) begin
      a = start + 32'(i) * 32'd4;
      sb.push_back({memword(a), a + 32'd4});
    end
  endtask

  task automatic wait_consumed(input string name, input int unsigned n);
    int unsigned target;
    target = consumed + n;
    for (int k = 0; k < 200 && consumed < target; k++) tick();
    chk(name, 32'(consumed >= target), 32'd1);
  endtask

  // Sample the bus mid-cycle for the memory model.
  always @(negedge clk) begin
    hs_s      <= bus.imem_req_valid && bus.imem_req_ready;
    hs_addr_s <= bus.imem_req_addr;
    rst_s     <= reset;
    given_s   <= bus.imem_resp_valid;
  end

  // Instruction memory: always ready, responds in order after mem_lat cycles.
  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (given_s && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (rst_s) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (hs_s) begin
        pend_addr.push_back(hs_addr_s);
        pend_due.push_back(cyc + mem_lat - 1);
      end
      #1;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memword(pend_addr[0]);
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end
    end
  end

  // Monitor: compare the presented head every cycle; it retires when not stalled.
  always @(negedge clk) begin
    if (reset !== 1'b1 && bus.redirect !== 1'b1 && bus.inst_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst: got instr=%h pc4=%h with nothing expected",
                 bus.inst_out, bus.pc_plus_four);
      end else begin
        if ({bus.inst_out, bus.pc_plus_four} !== sb[0]) begin
          errors++;
          $display("FAIL inst_stream: got instr=%h pc4=%h expected instr=%h pc4=%h",
                   bus.inst_out, bus.pc_plus_four, sb[0][63:32], sb[0][31:0]);
        end
        if (bus.stall === 1'b0) void'(sb.pop_front());
      end
      if (bus.stall === 1'b0) consumed++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    int unsigned c0;
    bit          found;

    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_req_ready  = 1'b1;

    // Reset values.
    tick(); tick();
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'h0);
    chk("rst_pc4", bus.pc_plus_four, 32'h0);

    // Zero-wait streaming from RESET_PC.
    tick();
    set_stream(32'h0);
    reset = 1'b0;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("first_req_addr", bus.imem_req_addr, 32'h0);
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
      end
      if (bus.inst_valid && first < 0) first = k;
    end
    // Cycle 0 requests, cycle 1 responds, cycle 2 presents (third cycle).
    chk("first_valid_cycle", 32'(first), 32'd2);
    tick();
    c0 = consumed;
    repeat (8) tick();
    chk("stream_rate", consumed - c0, 32'd8);

    // Backpressure: hold outputs, stop requesting, resume without gaps.
    bus.stall = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("stall_req_stop", 32'(bus.imem_req_valid), 32'd0);
    chk("stall_mem_idle", 32'(pend_addr.size()), 32'd0);
    tick();
    bus.stall = 1'b0;
    c0 = consumed;
    repeat (8) tick();
    chk("release_rate", consumed - c0, 32'd8);

    // Redirect with two requests in flight at 3-cycle latency.
    mem_lat = 3;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (pend_addr.size() == 2 && !bus.imem_resp_valid) found = 1'b1;
    end
    chk("inflight2_found", 32'(found), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    set_stream(32'h100);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("redir100_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("redir100_req_addr", bus.imem_req_addr, 32'h100);
    wait_consumed("redir100_progress", 6);

    // Redirect + stall + response in one cycle, unaligned target.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (bus.imem_resp_valid && pend_addr.size() == 2) found = 1'b1;
    end
    chk("resp_cycle_found", 32'(found), 32'd1);
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    set_stream(32'h200);
    tick();
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    @(negedge clk);
    chk("redir200_req_addr", bus.imem_req_addr, 32'h200);
    chk("redir200_inst_valid", 32'(bus.inst_valid), 32'd0);
    // One drop left, no outstanding: a request may issue while flushing.
    chk("redir200_flush_issue", 32'(bus.imem_req_valid), 32'd1);
    wait_consumed("redir200_progress", 6);

    // Back-to-back redirects: nothing from 0x40 may appear.
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    set_stream(32'h80);
    tick();
    bus.redirect_pc = 32'h0000_0080;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("b2b_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("b2b_req_addr", bus.imem_req_addr, 32'h80);
    wait_consumed("b2b_progress", 6);

    // Mid-stream reset with a partly filled buffer.
    mem_lat = 1;
    repeat (6) tick();
    bus.stall = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    set_stream(32'h0);
    tick();
    @(negedge clk);
    chk("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("midrst_req_addr", bus.imem_req_addr, 32'h0);
    chk("midrst_inst_out", bus.inst_out, 32'h0);
    chk("midrst_pc4", bus.pc_plus_four, 32'h0);
    tick();
    reset     = 1'b0;
    bus.stall = 1'b0;
    wait_consumed("restart_progress", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
